// File: rtl/display_scanner.sv
// display_scanner: 4-digit common-anode multiplexed 7-segment driver.
// Shows a 4-character window of MESSAGE starting at 2*address (wrapping mod 16).
// Optional macro BLANK_GAP_EN inserts an all-off BLANK state before each digit.
module display_scanner #(
    parameter logic [63:0] MESSAGE        = 64'hFEDCBA9876543210,
    parameter int unsigned REFRESH_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES   = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] address,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] digit,
    output logic       frame_start
);

    typedef enum logic {BLANK, DRIVE} state_t;

`ifdef BLANK_GAP_EN
    localparam state_t FIRST = BLANK;
`else
    localparam state_t FIRST = DRIVE;
`endif

    localparam logic [15:0] DRIVE_LAST = 16'(REFRESH_CYCLES - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);

    if (REFRESH_CYCLES < 1 || REFRESH_CYCLES > 65535 ||
        BLANK_CYCLES < 1 || BLANK_CYCLES > 65535) begin : g_bad_params
        $error("display_scanner: cycle parameters must be in 1..65535");
    end

    state_t      state, nxt_state;
    logic [1:0]  k, nxt_k;
    logic [15:0] cnt, nxt_cnt;
    logic [3:0]  start, nxt_start;
    logic        nxt_frame;
    // Set by reset so the first post-reset edge is treated as a frame entry.
    logic        fresh;
    logic [3:0]  idx;
    logic [3:0]  ch;

    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'h0: glyph = 7'b0000001;
            4'h1: glyph = 7'b1001111;
            4'h2: glyph = 7'b0010010;
            4'h3: glyph = 7'b0000110;
            4'h4: glyph = 7'b1001100;
            4'h5: glyph = 7'b0100100;
            4'h6: glyph = 7'b0100000;
            4'h7: glyph = 7'b0001111;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0000100;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b1100000;
            4'hC: glyph = 7'b0110001;
            4'hD: glyph = 7'b1000010;
            4'hE: glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
    endfunction

    // Next-state: timer, digit advance and frame-boundary address latch.
    always_comb begin
        nxt_state = state;
        nxt_k     = k;
        nxt_cnt   = cnt + 16'd1;
        nxt_start = start;
        nxt_frame = 1'b0;
        if (fresh) begin
            nxt_state = FIRST;
            nxt_k     = 2'd0;
            nxt_cnt   = '0;
            nxt_start = {address, 1'b0};
            nxt_frame = 1'b1;
        end
`ifdef BLANK_GAP_EN
        else if (state == BLANK && cnt == BLANK_LAST) begin
            nxt_state = DRIVE;
            nxt_cnt   = '0;
        end else if (state == DRIVE && cnt == DRIVE_LAST) begin
            nxt_state = BLANK;
            nxt_k     = k + 2'd1;
            nxt_cnt   = '0;
            if (k == 2'd3) begin
                nxt_start = {address, 1'b0};
                nxt_frame = 1'b1;
            end
        end
`else
        else if (cnt == DRIVE_LAST) begin
            nxt_k   = k + 2'd1;
            nxt_cnt = '0;
            if (k == 2'd3) begin
                nxt_start = {address, 1'b0};
                nxt_frame = 1'b1;
            end
        end
`endif
        idx = nxt_start + {2'b00, nxt_k};
        ch  = MESSAGE[{idx, 2'b00} +: 4];
    end

    // State registers and outputs, registered from the next-state values so
    // they line up with the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= FIRST;
            k           <= 2'd0;
            cnt         <= '0;
            start       <= '0;
            fresh       <= 1'b1;
            an          <= '1;
            seg         <= '1;
            dp          <= 1'b1;
            digit       <= 2'd0;
            frame_start <= 1'b0;
        end else begin
            state       <= nxt_state;
            k           <= nxt_k;
            cnt         <= nxt_cnt;
            start       <= nxt_start;
            fresh       <= 1'b0;
            dp          <= 1'b1;
            digit       <= nxt_k;
            frame_start <= nxt_frame;
            if (nxt_state == DRIVE) begin
                an  <= ~(4'b1000 >> nxt_k);
                seg <= glyph(ch);
            end else begin
                an  <= '1;
                seg <= '1;
            end
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: vector-table bench for display_scanner
// (REFRESH_CYCLES=4, BLANK_CYCLES=2); expectations follow BLANK_GAP_EN.
module tb_display_scanner;

    typedef struct {
        logic       rst;
        logic [2:0] addr;
        logic [3:0] an;
        logic [6:0] seg;
        logic [1:0] digit;
        logic       fs;
    } vec_t;

`ifdef BLANK_GAP_EN
    localparam int BL = 2;
`else
    localparam int BL = 0;
`endif
    localparam int SLOT   = BL + 4;
    localparam int PERIOD = 4 * SLOT;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] address;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] digit;
    logic       frame_start;

    vec_t vecs[$];
    logic [6:0] glyph_tab[16];
    logic [3:0] an_tab[4];
    int tests = 0;
    int fails = 0;

    display_scanner #(
        .MESSAGE        (64'hFEDCBA9876543210),
        .REFRESH_CYCLES (4),
        .BLANK_CYCLES   (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .digit       (digit),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    task automatic add(input logic r, input logic [2:0] a, input logic [3:0] e_an,
                       input logic [6:0] e_seg, input logic [1:0] e_dig, input logic e_fs);
        vec_t v;
        v.rst = r; v.addr = a; v.an = e_an; v.seg = e_seg; v.digit = e_dig; v.fs = e_fs;
        vecs.push_back(v);
    endtask

    // One frame: address 'early' before position 'sw', 'late' from then on;
    // chars packed {c3,c2,c1,c0}; only the first 'limit' cycles are added.
    task automatic add_frame(input logic [2:0] early, input logic [2:0] late, input int sw,
                             input logic [15:0] chars, input int limit);
        for (int p = 0; p < limit; p++) begin
            int kk;
            int q;
            logic [3:0] c;
            kk = p / SLOT;
            q  = p % SLOT;
            c  = chars[4*kk +: 4];
            if (q < BL)
                add(1'b0, (p < sw) ? early : late, 4'b1111, 7'b1111111, 2'(kk), p == 0);
            else
                add(1'b0, (p < sw) ? early : late, an_tab[kk], glyph_tab[c], 2'(kk), p == 0);
        end
    endtask

    task automatic check(input int n, input string name, input logic [6:0] act, input logic [6:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL v%0d %s: got %b want %b", n, name, act, exp);
        end
    endtask

    initial begin
        glyph_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        an_tab = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

        // reset held 3 cycles with address=5
        for (int i = 0; i < 3; i++) add(1'b1, 3'd5, 4'b1111, 7'b1111111, 2'd0, 1'b0);
        // window 0,1,2,3
        add_frame(3'd0, 3'd0, 0, 16'h3210, PERIOD);
        // address 7: E,F,0,1 with wrap
        add_frame(3'd7, 3'd7, 0, 16'h10FE, PERIOD);
        // address 0 latched, switched to 4 inside DRIVE(1): still 0,1,2,3
        add_frame(3'd0, 3'd4, SLOT + BL + 1, 16'h3210, PERIOD);
        // address 4 now visible: 8,9,A,b
        add_frame(3'd4, 3'd4, 0, 16'hBA98, PERIOD);
        // reset pulse two cycles into DRIVE(2)
        add_frame(3'd4, 3'd4, 0, 16'hBA98, 2 * SLOT + BL + 2);
        add(1'b1, 3'd4, 4'b1111, 7'b1111111, 2'd0, 1'b0);
        // fresh frame after reset, address 1: 2,3,4,5
        add_frame(3'd1, 3'd1, 0, 16'h5432, PERIOD);

        reset   = 1'b1;
        address = 3'd5;
        for (int i = 0; i < vecs.size(); i++) begin
            reset   = vecs[i].rst;
            address = vecs[i].addr;
            @(posedge clock);
            #1;
            check(i, "an",          {3'b000, an},          {3'b000, vecs[i].an});
            check(i, "seg",         seg,                   vecs[i].seg);
            check(i, "dp",          {6'b0, dp},            7'b0000001);
            check(i, "digit",       {5'b0, digit},         {5'b0, vecs[i].digit});
            check(i, "frame_start", {6'b0, frame_start},   {6'b0, vecs[i].fs});
            #3;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
